obi_hart_arbiter: RTL and testbench
===================================

# obi_hart_arbiter

Parametrised N-hart OBI arbiter: merges the data (or instruction) ports of `NumHarts` cores onto one OBI master port. Round-robin arbitration, request-hold (lock) across wait states, and in-order response routing through an outstanding-transaction FIFO. Sits between the per-hart ports of a multi-core CPU subsystem and the system bus, replacing the single-core, point-to-point connection.

## Interface
Parameters:
- `NumHarts`, 2, number of requesting harts (1..16).
- `MaxOutstanding`, 2, maximum accepted-but-unanswered transactions (1..8); depth of the routing FIFO.
- `IdxW`, `$clog2(NumHarts>1 ? NumHarts : 2)`, derived; width of the hart index.

Ports (`obi_req_t`/`obi_resp_t` from `obi_pkg`):
- `clk_i` in 1 — the block's single clock.
- `rst_i` in 1 — asynchronous, active-high reset.
- `hart_req_i` in `obi_req_t [NumHarts]` — per-hart request (req, we, be, addr, wdata).
- `hart_resp_o` out `obi_resp_t [NumHarts]` — per-hart gnt, rvalid, rdata.
- `bus_req_o` out `obi_req_t` — merged request to system bus.
- `bus_resp_i` in `obi_resp_t` — system bus gnt, rvalid, rdata.
- `busy_o` out 1 — FIFO non-empty (transactions outstanding).
- `err_o` out 1 — sticky: rvalid received with FIFO empty.

## Operation
- Eligible request: `hart_req_i[i].req` high. `bus_req_o.req` = any eligible AND FIFO not full.
- Selection: when unlocked, pick first eligible hart starting at `rr_ptr`, ascending, wrapping. When locked, selection = `lock_idx`.
- Lock: set when `bus_req_o.req`=1 and `bus_resp_i.gnt`=0; `lock_idx` = current selection. Cleared on the handshake (req & gnt). Guarantees OBI address/data stability until grant.
- `bus_req_o` {we, be, addr, wdata} = selected hart's fields; all zero when `bus_req_o.req`=0.
- Grant: `hart_resp_o[sel].gnt` = `bus_resp_i.gnt` & `bus_req_o.req`; all other gnt = 0.
- On handshake: push `sel` into FIFO; `rr_ptr` <= (sel+1) mod `NumHarts`.
- On `bus_resp_i.rvalid` with FIFO non-empty: pop head; `hart_resp_o[head].rvalid`=1, `rdata` = `bus_resp_i.rdata`. `rdata` of all other harts = `bus_resp_i.rdata` (rvalid 0).
- `rvalid` with FIFO empty: dropped, no hart sees rvalid; `err_o` set, cleared only by reset.
- Push and pop in the same cycle: both occur; count unchanged.
- Full: no new request issued (req gated). A pop in the same cycle does not unblock that cycle (no bypass).
- `NumHarts`=1: pure pass-through plus FIFO bookkeeping; `rr_ptr` constant 0.

## Timing
- Request path combinational: hart req -> `bus_req_o` same cycle; gnt -> hart gnt same cycle.
- Response routing combinational from FIFO head: `bus_resp_i.rvalid` -> `hart_resp_o[head].rvalid` same cycle, zero added latency.
- Registers update on rising `clk_i`: FIFO pointers/count, `rr_ptr`, lock, `lock_idx`, `err_o`.
- Reset values: FIFO empty, count 0, `rr_ptr` 0, lock 0, `err_o` 0. Outputs during reset: `bus_req_o.req` follows hart requests (FIFO empty, not full); `busy_o` 0; all gnt/rvalid 0 unless driven by the bus.
- Reset mid-operation: outstanding entries discarded; any later rvalid for them sets `err_o`.
- Back-to-back: one handshake per cycle sustained while not full and bus grants every cycle.

## Test plan
- Single hart: hart0 read, addr 0x1000, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> hart0 gnt in cycle 0, rvalid+rdata in cycle 2, hart1 sees nothing; `busy_o` high cycles 1–2.
- Fairness: NumHarts=3, all request continuously, bus always grants -> grant order 0,1,2,0,1,2; each hart gets 1/3 of the grants.
- Lock: hart1 requests, gnt held low 3 cycles while hart0 raises req -> `bus_req_o.addr` stays hart1's addr until gnt; hart0 is granted next.
- Full: MaxOutstanding=2, two grants with no rvalid -> third request sees `bus_req_o.req`=0; after one rvalid, the next cycle issues it.
- Ordering: grants to hart2 then hart0, rvalids with 0xA, 0xB -> hart2 receives 0xA, hart0 receives 0xB.
- Error/reset: rvalid with FIFO empty -> `err_o`=1 and held; assert `rst_i` mid-transaction -> `err_o`=0, `busy_o`=0, `rr_ptr` 0 asynchronously.

Source files
------------

// File: rtl/obi_hart_arbiter.sv
// N-hart OBI arbiter: round-robin with request lock across wait states, in-order
// response routing through a FIFO of granted hart indices.

package obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_hart_arbiter #(
    parameter int unsigned NumHarts       = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned IdxW           = $clog2(NumHarts > 1 ? NumHarts : 2)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  obi_pkg::obi_req_t   hart_req_i  [NumHarts],
    output obi_pkg::obi_resp_t  hart_resp_o [NumHarts],
    output obi_pkg::obi_req_t   bus_req_o,
    input  obi_pkg::obi_resp_t  bus_resp_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam int unsigned PtrW = $clog2(MaxOutstanding > 1 ? MaxOutstanding : 2);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;

    logic            any_req;
    logic            full;
    logic            empty;
    logic            issue;
    logic            push;
    logic            pop;
    logic            found;
    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] head;
    int unsigned     rot;

    assign full  = (count_q == CntW'(MaxOutstanding));
    assign empty = (count_q == '0);
    assign issue = any_req & ~full;
    assign push  = issue & bus_resp_i.gnt;
    assign pop   = bus_resp_i.rvalid & ~empty;

    // Unlocked: first requester at or after rr_ptr, wrapping.
    always_comb begin
        any_req = 1'b0;
        found   = 1'b0;
        sel     = rr_ptr_q;
        rot     = 0;
        for (int unsigned i = 0; i < NumHarts; i++) begin
            any_req = any_req | hart_req_i[i].req;
        end
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < NumHarts; k++) begin
                rot = 32'(rr_ptr_q) + k;
                if (rot >= NumHarts) begin
                    rot = rot - NumHarts;
                end
                for (int unsigned i = 0; i < NumHarts; i++) begin
                    if (!found && (i == rot) && hart_req_i[i].req) begin
                        found = 1'b1;
                        sel   = IdxW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        head = '0;
        for (int unsigned e = 0; e < MaxOutstanding; e++) begin
            if (PtrW'(e) == rd_ptr_q) begin
                head = fifo_q[e];
            end
        end
    end

    always_comb begin
        bus_req_o = '0;
        if (issue) begin
            for (int unsigned i = 0; i < NumHarts; i++) begin
                if (IdxW'(i) == sel) begin
                    bus_req_o = hart_req_i[i];
                end
            end
        end
        bus_req_o.req = issue;
    end

    always_comb begin
        for (int unsigned i = 0; i < NumHarts; i++) begin
            hart_resp_o[i].gnt    = push & (IdxW'(i) == sel);
            hart_resp_o[i].rvalid = pop & (IdxW'(i) == head);
            hart_resp_o[i].rdata  = bus_resp_i.rdata;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (bus_resp_i.rvalid & empty);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            rr_ptr_d = (sel == IdxW'(NumHarts - 1)) ? '0 : sel + IdxW'(1);
            lock_d   = 1'b0;
        end else if (issue) begin
            // Hold the selection until granted so address/data stay stable.
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int unsigned e = 0; e < MaxOutstanding; e++) begin
                if (PtrW'(e) == wr_ptr_q) begin
                    fifo_q[e] <= sel;
                end
            end
        end
    end

    assign busy_o = ~empty;
    assign err_o  = err_q;

endmodule

// File: tb/tb_obi_hart_arbiter.sv
// Randomized and directed bench for obi_hart_arbiter against a queue-based model.

module tb_obi_hart_arbiter;
    import obi_pkg::*;

    localparam int N = 3;
    localparam int M = 2;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    obi_req_t  hreq  [N];
    obi_resp_t hresp [N];
    obi_req_t  breq;
    obi_resp_t bresp;
    logic      busy;
    logic      err;

    always #5 clk = ~clk;

    obi_hart_arbiter #(
        .NumHarts      (N),
        .MaxOutstanding(M)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .hart_req_i (hreq),
        .hart_resp_o(hresp),
        .bus_req_o  (breq),
        .bus_resp_i (bresp),
        .busy_o     (busy),
        .err_o      (err)
    );

    // Model state: queue of granted harts in order, round-robin start, pending lock.
    int       q[$];
    int       rr;
    bit       locked;
    int       lk;
    bit       merr;
    obi_req_t e_req;
    bit       e_gnt [N];
    bit       e_rv  [N];
    bit       e_pop;
    bit       e_issue;
    int       e_sel;

    int vectors = 0;
    int miscompares = 0;
    int cnt [N];
    bit held [N];

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic obi_req_t mkreq(logic [31:0] a, logic w, logic [31:0] wd);
        obi_req_t r;
        r = '{req: 1'b1, we: w, be: 4'hF, addr: a, wdata: wd};
        return r;
    endfunction

    function automatic void model_reset();
        q.delete();
        rr = 0;
        locked = 0;
        lk = 0;
        merr = 0;
    endfunction

    function automatic void model_eval();
        bit anyr;
        bit fnd;
        anyr = 0;
        fnd = 0;
        for (int i = 0; i < N; i++) anyr |= hreq[i].req;
        e_issue = anyr && (q.size() < M);
        e_sel = rr;
        if (locked) e_sel = lk;
        else begin
            for (int k = 0; k < N; k++) begin
                if (!fnd && hreq[(rr + k) % N].req) begin
                    fnd = 1;
                    e_sel = (rr + k) % N;
                end
            end
        end
        e_req = '0;
        if (e_issue) begin
            e_req = hreq[e_sel];
            e_req.req = 1'b1;
        end
        e_pop = bresp.rvalid && (q.size() > 0);
        for (int i = 0; i < N; i++) begin
            e_gnt[i] = e_issue && bresp.gnt && (i == e_sel);
            e_rv[i]  = e_pop && (q[0] == i);
        end
    endfunction

    function automatic void model_update();
        if (rst) begin
            model_reset();
            return;
        end
        if (bresp.rvalid && q.size() == 0) merr = 1;
        if (e_pop) void'(q.pop_front());
        if (e_issue && bresp.gnt) begin
            q.push_back(e_sel);
            rr = (e_sel + 1) % N;
            locked = 0;
        end else if (e_issue) begin
            locked = 1;
            lk = e_sel;
        end
    endfunction

    function automatic void compare_all();
        chk("bus_req", breq, e_req);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("gnt%0d", i), hresp[i].gnt, e_gnt[i]);
            chk($sformatf("rvalid%0d", i), hresp[i].rvalid, e_rv[i]);
            chk($sformatf("rdata%0d", i), hresp[i].rdata, bresp.rdata);
        end
        chk("busy", busy, q.size() != 0);
        chk("err", err, merr);
    endfunction

    task automatic settle();
        @(negedge clk);
        model_eval();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) hreq[i] = '0;
        bresp = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        model_reset();
        #2;
        do_reset();

        // Reset state
        settle();
        chk("reset_bus_req", breq.req, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", err, 1'b0);
        tick();

        // Single read
        hreq[0] = mkreq(32'h1000, 1'b0, 32'h0);
        bresp.gnt = 1'b1;
        settle();
        chk("single_gnt0", hresp[0].gnt, 1'b1);
        chk("single_gnt1", hresp[1].gnt, 1'b0);
        chk("single_addr", breq.addr, 32'h1000);
        tick();
        idle();
        settle();
        chk("single_busy1", busy, 1'b1);
        tick();
        bresp.rvalid = 1'b1;
        bresp.rdata = 32'hDEADBEEF;
        settle();
        chk("single_rvalid0", hresp[0].rvalid, 1'b1);
        chk("single_rdata0", hresp[0].rdata, 32'hDEADBEEF);
        chk("single_rvalid1", hresp[1].rvalid, 1'b0);
        chk("single_busy2", busy, 1'b1);
        tick();
        idle();
        settle();
        chk("single_idle", busy, 1'b0);
        tick();

        // Fairness
        do_reset();
        for (int i = 0; i < N; i++) begin
            hreq[i] = mkreq(32'h100 * i, 1'b0, 32'h0);
            cnt[i] = 0;
        end
        bresp.gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            int got;
            bresp.rvalid = (q.size() > 0);
            settle();
            got = -1;
            for (int i = 0; i < N; i++) if (hresp[i].gnt) got = i;
            chk("fair_grant", got, c % 3);
            if (got >= 0) cnt[got]++;
            tick();
        end
        for (int i = 0; i < N; i++) chk("fair_count", cnt[i], 2);

        // Lock across wait states
        do_reset();
        hreq[1] = mkreq(32'h2000, 1'b1, 32'h1111);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) hreq[0] = mkreq(32'h3000, 1'b0, 32'h0);
            settle();
            chk("lock_addr", breq.addr, 32'h2000);
            chk("lock_gnt0", hresp[0].gnt, 1'b0);
            tick();
        end
        bresp.gnt = 1'b1;
        settle();
        chk("lock_gnt1", hresp[1].gnt, 1'b1);
        tick();
        hreq[1] = '0;
        settle();
        chk("lock_next_gnt0", hresp[0].gnt, 1'b1);
        chk("lock_next_addr", breq.addr, 32'h3000);
        tick();

        // Full, no bypass
        do_reset();
        bresp.gnt = 1'b1;
        hreq[0] = mkreq(32'h10, 1'b0, 32'h0);
        step();
        hreq[0] = '0;
        hreq[1] = mkreq(32'h20, 1'b0, 32'h0);
        step();
        hreq[1] = '0;
        hreq[2] = mkreq(32'h30, 1'b0, 32'h0);
        settle();
        chk("full_req", breq.req, 1'b0);
        chk("full_gnt2", hresp[2].gnt, 1'b0);
        tick();
        bresp.rvalid = 1'b1;
        settle();
        chk("full_nobypass", breq.req, 1'b0);
        chk("full_pop0", hresp[0].rvalid, 1'b1);
        tick();
        bresp.rvalid = 1'b0;
        settle();
        chk("full_reissue", breq.req, 1'b1);
        chk("full_gnt2b", hresp[2].gnt, 1'b1);
        tick();

        // Ordering
        do_reset();
        bresp.gnt = 1'b1;
        hreq[2] = mkreq(32'h200, 1'b0, 32'h0);
        step();
        hreq[2] = '0;
        hreq[0] = mkreq(32'h000, 1'b0, 32'h0);
        step();
        idle();
        bresp.rvalid = 1'b1;
        bresp.rdata = 32'hA;
        settle();
        chk("order_rv2", hresp[2].rvalid, 1'b1);
        chk("order_rd2", hresp[2].rdata, 32'hA);
        chk("order_rv0a", hresp[0].rvalid, 1'b0);
        tick();
        bresp.rdata = 32'hB;
        settle();
        chk("order_rv0", hresp[0].rvalid, 1'b1);
        chk("order_rd0", hresp[0].rdata, 32'hB);
        chk("order_rv2b", hresp[2].rvalid, 1'b0);
        tick();

        // Stray rvalid
        do_reset();
        bresp.rvalid = 1'b1;
        bresp.rdata = 32'h5;
        settle();
        chk("err_drop0", hresp[0].rvalid, 1'b0);
        tick();
        idle();
        settle();
        chk("err_set", err, 1'b1);
        tick();
        repeat (3) step();
        settle();
        chk("err_held", err, 1'b1);
        tick();

        // Reset mid-transaction
        bresp.gnt = 1'b1;
        hreq[1] = mkreq(32'h40, 1'b0, 32'h0);
        step();
        idle();
        settle();
        chk("mid_busy", busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_async_busy", busy, 1'b0);
        chk("mid_async_err", err, 1'b0);
        tick();
        rst = 1'b0;
        bresp.rvalid = 1'b1;
        step();
        idle();
        settle();
        chk("mid_stale_err", err, 1'b1);
        tick();
        for (int i = 0; i < N; i++) hreq[i] = mkreq(32'h500 + i, 1'b0, 32'h0);
        bresp.gnt = 1'b1;
        settle();
        chk("mid_rr_zero", hresp[0].gnt, 1'b1);
        tick();

        // Randomized traffic with OBI request hold
        do_reset();
        for (int i = 0; i < N; i++) held[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!held[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        hreq[i] = mkreq($urandom, 1'($urandom), $urandom);
                        hreq[i].be = 4'($urandom);
                    end else begin
                        hreq[i] = '0;
                    end
                end
            end
            bresp.gnt = ($urandom_range(2, 0) != 0);
            bresp.rvalid = (q.size() > 0) ? ($urandom_range(1, 0) == 1)
                                          : ($urandom_range(63, 0) == 0);
            bresp.rdata = $urandom;
            settle();
            tick();
            for (int i = 0; i < N; i++) held[i] = hreq[i].req && !e_gnt[i];
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
